// File: rtl/fifo_seq.sv
// Load/drain sequencer: streams DEPTH*DEPTH beats row-major into DEPTH shift FIFOs,
// then drains them with a diagonal skew. Optional abort input under FIFO_SEQ_ABORT_EN.
module fifo_seq #(
   parameter int DEPTH = 8,
   parameter int BITS  = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic [BITS-1:0]  in_data,
`ifdef FIFO_SEQ_ABORT_EN
   input  logic             abort,
`endif
   output logic             in_ready,
   output logic [DEPTH-1:0] fifo_en,
   output logic [BITS-1:0]  fifo_d,
   output logic [DEPTH-1:0] drain_active,
   output logic             busy,
   output logic             done
);
   localparam int LG = $clog2(DEPTH);
   localparam int BW = 2 * LG;
   localparam int CW = LG + 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(DEPTH * DEPTH - 1);
   localparam logic [CW-1:0] LAST_CNT  = CW'(2 * DEPTH - 2);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

   state_t         r_state;
   logic [BW-1:0]  r_beat;
   logic [CW-1:0]  r_cnt;

   logic             w_abort;
   logic             w_ready;
   logic             w_acc;
   logic             w_drain;
   logic [LG-1:0]    w_row;
   logic [DEPTH-1:0] w_diag;

`ifdef FIFO_SEQ_ABORT_EN
   assign w_abort = abort && (r_state == S_LOAD || r_state == S_DRAIN);
`else
   assign w_abort = 1'b0;
`endif

   assign w_ready = (r_state == S_LOAD) && !w_abort;
   assign w_acc   = w_ready && in_valid;
   assign w_drain = (r_state == S_DRAIN) && !w_abort;
   assign w_row   = r_beat[BW-1:LG];

   // c - i wraps to >= DEPTH+1 when c < i, so one unsigned compare covers i <= c < i+DEPTH
   for (genvar i = 0; i < DEPTH; i++) begin : g_diag
      logic [CW-1:0] w_off;
      assign w_off     = r_cnt - CW'(i);
      assign w_diag[i] = (w_off < CW'(DEPTH));
   end

   always_comb begin
      fifo_en = '0;
      if (w_acc)
         fifo_en[w_row] = 1'b1;
      else if (w_drain)
         fifo_en = w_diag;
   end

   assign fifo_d       = w_acc ? in_data : '0;
   assign drain_active = w_drain ? w_diag : '0;
   assign in_ready     = w_ready;
   assign busy         = (r_state == S_LOAD) || (r_state == S_DRAIN);
   assign done         = (r_state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_beat  <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_LOAD;
                  r_beat  <= '0;
               end
            end
            S_LOAD: begin
               if (w_abort) begin
                  r_state <= S_IDLE;
                  r_beat  <= '0;
                  r_cnt   <= '0;
               end else if (w_acc) begin
                  if (r_beat == LAST_BEAT) begin
                     r_state <= S_DRAIN;
                     r_beat  <= '0;
                     r_cnt   <= '0;
                  end else begin
                     r_beat <= r_beat + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (w_abort) begin
                  r_state <= S_IDLE;
                  r_beat  <= '0;
                  r_cnt   <= '0;
               end else if (r_cnt == LAST_CNT) begin
                  r_state <= S_DONE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_seq.sv
// Self-checking bench for fifo_seq (DEPTH=8, BITS=64): vector table, directed corner
// sequences and randomized traffic against a sequence-level reference model.
module tb_fifo_seq;
   localparam int D = 8;
   localparam int B = 64;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic         in_valid = 1'b0;
   logic [B-1:0] in_data = '0;
`ifdef FIFO_SEQ_ABORT_EN
   logic         abort = 1'b0;
`endif
   logic         in_ready;
   logic [D-1:0] fifo_en;
   logic [B-1:0] fifo_d;
   logic [D-1:0] drain_active;
   logic         busy;
   logic         done;

   fifo_seq #(.DEPTH(D), .BITS(B)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
`ifdef FIFO_SEQ_ABORT_EN
      .abort(abort),
`endif
      .in_ready(in_ready), .fifo_en(fifo_en), .fifo_d(fifo_d),
      .drain_active(drain_active), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference model: phase 0 idle, 1 load, 2 drain, 3 done
   int m_phase = 0, m_k = 0, m_c = 0;
   int cyc = 0, n_done = 0, n_acc = 0, last_beat_cyc = 0, done_cyc = 0;

   logic         o_rdy, o_busy, o_done;
   logic [D-1:0] o_en;
   logic [B-1:0] o_d;

   typedef struct {
      logic         st, vld;
      logic [B-1:0] data;
      logic         rdy;
      logic [D-1:0] en;
      logic [B-1:0] d;
      logic         bsy, dn;
   } vec_t;

   function automatic logic [D-1:0] diag(int c);
      logic [D-1:0] r = '0;
      for (int i = 0; i < D; i++)
         if (i <= c && c < i + D) r[i] = 1'b1;
      return r;
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_k = 0; m_c = 0;
   endtask

   task automatic step();
      logic ab, acc;
      logic [D-1:0] een;
      logic [B-1:0] ed;
      @(negedge clk);
      ab = 1'b0;
`ifdef FIFO_SEQ_ABORT_EN
      ab = abort && (m_phase == 1 || m_phase == 2);
`endif
      acc = (m_phase == 1) && in_valid && !ab;
      if (acc) een = D'(1) << (m_k / D);
      else if (m_phase == 2 && !ab) een = diag(m_c);
      else een = '0;
      ed = acc ? in_data : '0;
      o_rdy = in_ready; o_en = fifo_en; o_d = fifo_d; o_busy = busy; o_done = done;
      chk("cycle", {in_ready, fifo_en, fifo_d, drain_active, busy, done},
          {(m_phase == 1) && !ab, een, ed, (m_phase == 2 && !ab) ? een : D'(0),
           (m_phase == 1 || m_phase == 2), (m_phase == 3)});
      if (done) begin n_done++; done_cyc = cyc; end
      if (in_valid && in_ready) n_acc++;
      if (acc && m_k == D * D - 1) last_beat_cyc = cyc;
      @(posedge clk);
      if (ab) model_reset();
      else case (m_phase)
         0: if (start) begin m_phase = 1; m_k = 0; end
         1: if (acc) begin
               m_k++;
               if (m_k == D * D) begin m_phase = 2; m_c = 0; m_k = 0; end
            end
         2: begin m_c++; if (m_c == 2 * D - 1) begin m_phase = 3; m_c = 0; end end
         default: m_phase = 0;
      endcase
      cyc++;
      #1;
   endtask

   task automatic do_start();
      start = 1'b1; in_valid = 1'b0; step(); start = 1'b0;
   endtask

   task automatic load_b2b();
      int g = 0;
      while (m_phase == 1 && g < 200) begin
         in_valid = 1'b1; in_data = B'(m_k); step(); g++;
      end
      in_valid = 1'b0;
      if (g >= 200) chk("load_timeout", 1, 0);
   endtask

   task automatic finish_seq();
      int g = 0;
      while (m_phase != 0 && g < 300) begin
         in_valid = 1'b1; in_data = B'(m_k); step(); g++;
      end
      in_valid = 1'b0;
      if (g >= 300) chk("finish_timeout", 1, 0);
   endtask

   initial begin
      vec_t vt[5];
      logic [D-1:0] drain_tbl[15];
      int b, g, dc, nd0;

      drain_tbl = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                    8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
      vt[0] = '{1'b0, 1'b1, 64'h55, 1'b0, 8'h00, 64'h0,  1'b0, 1'b0};
      vt[1] = '{1'b1, 1'b0, 64'h0,  1'b0, 8'h00, 64'h0,  1'b0, 1'b0};
      vt[2] = '{1'b0, 1'b1, 64'hA0, 1'b1, 8'h01, 64'hA0, 1'b1, 1'b0};
      vt[3] = '{1'b0, 1'b0, 64'h0,  1'b1, 8'h00, 64'h0,  1'b1, 1'b0};
      vt[4] = '{1'b1, 1'b1, 64'hA1, 1'b1, 8'h01, 64'hA1, 1'b1, 1'b0};

      // reset state
      #2 rst_n = 1'b0;
      #2 chk("reset_outs", {in_ready, fifo_en, fifo_d, drain_active, busy, done}, '0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // vector table: idle, start, first beats with a gap and an ignored start
      for (int i = 0; i < 5; i++) begin
         start = vt[i].st; in_valid = vt[i].vld; in_data = vt[i].data;
         step();
         chk($sformatf("vec%0d", i), {o_rdy, o_en, o_d, o_busy, o_done},
             {vt[i].rdy, vt[i].en, vt[i].d, vt[i].bsy, vt[i].dn});
      end
      start = 1'b0;

      // full back-to-back sequence with in_data = k
      g = 0;
      while (m_phase == 1 && g < 200) begin
         b = m_k; in_valid = 1'b1; in_data = B'(b); step(); g++;
         if (b < 8) chk("row0_en", o_en, 8'h01);
         if (b >= 56) chk("row7_en", o_en, 8'h80);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         start = (i == 3); in_valid = 1'($urandom_range(0, 1));
         step();
         chk($sformatf("drain_en c=%0d", i), o_en, drain_tbl[i]);
      end
      start = 1'b0; in_valid = 1'b0;
      step();
      chk("done_pulse", o_done, 1'b1);
      chk("done_count", n_done, 1);
      chk("done_latency", done_cyc - last_beat_cyc, 16);
      step();

      // stalls: in_valid every other cycle, start pulses inside LOAD and DRAIN
      n_acc = 0; nd0 = n_done;
      do_start();
      g = 0;
      while (m_phase == 1 && g < 400) begin
         start = (g == 10); in_valid = (g % 2 == 1); in_data = B'($urandom);
         step();
         if (g == 0) chk("ready_after_start", o_rdy, 1'b1);
         g++;
      end
      start = 1'b0; in_valid = 1'b0;
      chk("stall_beats", n_acc, 64);
      dc = 0; g = 0;
      while (g < 40) begin
         start = (g == 2); step(); g++;
         if (o_done) break;
         if (o_busy && !o_rdy) dc++;
      end
      start = 1'b0;
      chk("stall_drain_len", dc, 15);
      chk("stall_done_count", n_done - nd0, 1);
      step();

      // reset at DRAIN c=5
      do_start();
      load_b2b();
      repeat (5) step();
      nd0 = n_done;
      rst_n = 1'b0;
      #1 chk("rst_drain_outs", {in_ready, fifo_en, fifo_d, drain_active, busy, done}, '0);
      model_reset();
      repeat (2) begin
         @(negedge clk);
         chk("rst_held_outs", {in_ready, fifo_en, fifo_d, drain_active, busy, done}, '0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_start();
      in_valid = 1'b1; in_data = 64'hBEEF; step();
      chk("rst_first_beat", o_en, 8'h01);
      chk("rst_no_done", n_done, nd0);
      finish_seq();

`ifdef FIFO_SEQ_ABORT_EN
      do_start();
      repeat (21) begin in_valid = 1'b1; in_data = B'(m_k); step(); end
      abort = 1'b1; in_valid = 1'b1; step();
      chk("abort_en", o_en, 8'h00);
      abort = 1'b0; in_valid = 1'b1; nd0 = n_done; step();
      chk("abort_next", {o_rdy, o_busy, o_done}, 3'b000);
      do_start();
      in_valid = 1'b1; in_data = 64'h7; step();
      chk("abort_restart", o_en, 8'h01);
      finish_seq();
      chk("abort_no_done", n_done - nd0, 1);
`endif

      // randomized traffic against the model
      repeat (1500) begin
         start = ($urandom_range(0, 7) == 0);
         in_valid = 1'($urandom_range(0, 1));
         in_data = {$urandom, $urandom};
`ifdef FIFO_SEQ_ABORT_EN
         abort = ($urandom_range(0, 63) == 0);
`endif
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_seq.md
FIFO_SEQ -- requirements
Module: fifo_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving both the FIFO count and the entries per FIFO; legal values are powers of two, 2..16.
REQ-002 SHALL have parameter BITS, default 64, giving the data width.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: begin a load/drain sequence.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data beat offered.
REQ-007 SHALL have port in_data, input, BITS bits: load beat.
REQ-008 SHALL have port in_ready, output, 1 bit: beat is accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port fifo_en, output, DEPTH bits: per-FIFO shift enable.
REQ-010 SHALL have port fifo_d, output, BITS bits: shift-in data common to all FIFOs.
REQ-011 SHALL have port drain_active, output, DEPTH bits: FIFO i is presenting a valid entry this cycle.
REQ-012 SHALL have port busy, output, 1 bit: high in LOAD or DRAIN.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 SHALL implement four states: IDLE, LOAD, DRAIN and DONE.
REQ-015 In IDLE, start=1 SHALL move the block to LOAD on the next edge; start SHALL be ignored in every other state.
REQ-016 In LOAD, in_ready SHALL be 1; in all other states in_ready SHALL be 0.
REQ-017 LOAD SHALL accept exactly DEPTH*DEPTH beats, numbered k = 0..DEPTH*DEPTH-1 in row-major order. Beat k targets FIFO k/DEPTH.
REQ-018 On an accepted beat, fifo_en SHALL be combinationally one-hot at bit k/DEPTH and fifo_d SHALL equal in_data. With no accepted beat, fifo_en SHALL be 0. in_valid gaps SHALL stall the sequence without loss.
REQ-019 Acceptance of beat DEPTH*DEPTH-1 SHALL move the block to DRAIN on the next edge, with the drain counter c at 0.
REQ-020 In DRAIN, fifo_en[i] SHALL be 1 exactly when i <= c < i+DEPTH, which gives the diagonal skew. fifo_d SHALL be 0 and drain_active SHALL equal fifo_en.
REQ-021 c SHALL increment every DRAIN cycle. The cycle with c = 2*DEPTH-2 SHALL be the last DRAIN cycle, so DRAIN lasts 2*DEPTH-1 cycles, then the block moves to DONE.
REQ-022 DONE SHALL last one cycle with done=1, then move to IDLE. The earliest accepted start after that is in the following cycle.
REQ-023 Outside DRAIN, drain_active SHALL be 0. Outside LOAD and DRAIN, fifo_en SHALL be 0 and fifo_d SHALL be 0.
REQ-024 The beat counter SHALL be 2*log2(DEPTH) bits wide and the drain counter log2(DEPTH)+1 bits wide. Neither SHALL wrap within a sequence.

Reset
REQ-025 rst_n low SHALL asynchronously force the state to IDLE, clear both counters, and drive every output to 0.
REQ-026 Reset asserted during LOAD or DRAIN SHALL abandon the sequence, with no done pulse. The first start after reset SHALL begin at beat 0.

Configuration
REQ-027 Macro FIFO_SEQ_ABORT_EN SHALL control the abort feature.
- Defined: add input abort, 1 bit. abort=1 in LOAD or DRAIN SHALL move the block to IDLE on the next edge, clear both counters, and suppress done. In that abort cycle fifo_en SHALL be 0 and no beat is accepted.
- Undefined: no abort port exists and sequences always run to completion.

Verification (DEPTH=8, BITS=64)
REQ-028 Full sequence: start, then 64 back-to-back beats with in_data=k.
- fifo_en = 8'h01 for beats 0..7 and 8'h80 for beats 56..63.
- DRAIN lasts 15 cycles: fifo_en = 8'h01, 8'h03 ... 8'hFF at c=7 ... 8'h80 at c=14.
- done pulses once, in the 16th cycle after the last beat.
REQ-029 Stalls: in_valid toggling every other cycle during LOAD -> exactly 64 beats accepted, fifo_en=0 on idle cycles, DRAIN timing identical to REQ-028.
REQ-030 start pulsed during LOAD and during DRAIN -> no effect. start in IDLE -> in_ready=1 on the next cycle.
REQ-031 rst_n dropped at DRAIN c=5 -> all outputs 0 immediately, no done pulse. A new start then accepts its first beat into FIFO 0.
REQ-032 With FIFO_SEQ_ABORT_EN defined, abort after beat 20 -> IDLE on the next cycle with in_ready=0 and done=0. A following start restarts at beat 0.
